// File: rtl/matrix_operand_fetch.sv
// matrix_operand_fetch: Avalon-MM read master that streams RAM words out as little-endian bytes.
module matrix_operand_fetch #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [15:0]       rd_left_q;
  logic [17:0]       bytes_left_q;
  logic              inflight_q;
  logic              done_q;
  logic [PW:0]       count_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [1:0]        idx_q;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic              issue;
  logic              hs;
  logic              pop;
  logic [31:0]       head;
  // Counting the in-flight read as occupied space keeps the FIFO from overflowing.
  assign issue          = state_q == RUN && rd_left_q != '0 &&
                          int'(count_q) + int'(inflight_q) < FIFO_DEPTH;
  assign out_valid      = count_q != '0;
  assign hs             = out_valid && out_ready;
  assign pop            = hs && idx_q == 2'd3;
  assign head           = fifo_q[rd_ptr_q];
  assign out_data       = out_valid ? head[{idx_q, 3'b000} +: 8] : '0;
  assign out_last       = out_valid && bytes_left_q == 18'd1;
  assign busy           = state_q == RUN;
  assign done           = done_q;
  assign mem_address    = rd_addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_left_q    <= '0;
      bytes_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (state_q == IDLE && start) begin
        if (word_count != '0) begin
          state_q      <= RUN;
          rd_addr_q    <= base_addr;
          rd_left_q    <= word_count;
          bytes_left_q <= {word_count, 2'b00};
        end else begin
          done_q <= 1'b1;
        end
      end
      if (issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        rd_left_q <= rd_left_q - 1'b1;
      end
      if (inflight_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(inflight_q) - (PW+1)'(pop);
      if (hs) begin
        idx_q        <= idx_q + 1'b1;
        bytes_left_q <= bytes_left_q - 1'b1;
      end
      if (hs && bytes_left_q == 18'd1) begin
        state_q <= IDLE;
        done_q  <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= mem_readdata;
  end
endmodule

// File: doc/matrix_operand_fetch.md
# matrix_operand_fetch

Avalon-MM read master that pulls 32-bit words from the 32768-word on-chip RAM (second slave port) and serialises them into an 8-bit operand stream for the matrix-multiply datapath. It issues single-word reads at a fixed read latency of 1, buffers returned words in a small FIFO so the stream sink can apply backpressure, and unpacks each word little-endian into bytes. It sits between the on-chip memory and the MAC array's operand input.

## Interface
Parameters:
- `ADDR_W`, 15: word-address width; matches the RAM depth.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  1-cycle request; sampled only while `busy`=0.
- `base_addr`  in  ADDR_W  first word address; captured on accepted `start`.
- `word_count`  in  16  number of words, 0..32768; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  1-cycle pulse when the transfer completes.
- `mem_address`  out  ADDR_W  read word address.
- `mem_chipselect`  out  1  read strobe; one word per asserted cycle.
- `mem_write`  out  1  constant 0.
- `mem_byteenable`  out  4  constant 4'hF.
- `mem_clken`  out  1  constant 1.
- `mem_readdata`  in  32  RAM data; valid the cycle after the strobe.
- `out_data`  out  8  operand byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte when `out_valid` & `out_ready`.
- `out_last`  out  1  marks the final byte of the transfer; qualified by `out_valid`.

## Operation
- States: IDLE, RUN.
  - IDLE → RUN on `start` with `word_count`≠0. Load `rd_addr`=`base_addr`, `rd_left`=`word_count`, `bytes_left`=4×`word_count`.
  - `start` with `word_count`=0 → `done` next cycle, no reads issued, `busy` stays 0.
  - RUN → IDLE when the last byte handshakes. `done` pulses in the following cycle and `busy` drops in that same cycle.
- Issue rule: in RUN, assert `mem_chipselect` when `rd_left`≠0 and (`fifo_count` + `inflight`) < `FIFO_DEPTH`. `inflight` is 0 or 1.
  - On each issue: `rd_addr`+1 (wraps modulo 2^ADDR_W, so 32767 → 0) and `rd_left`−1.
- Capture: `mem_readdata` is pushed into the FIFO in the cycle after an issue. The FIFO never overflows, by construction of the issue rule.
- Unpacker: holds the head word and a 2-bit byte index.
  - `out_data` = word[8·idx+7 : 8·idx], starting at idx 0 (bits 7:0).
  - Each handshake advances idx. On idx=3 it pops the FIFO and idx returns to 0.
- `out_last` = (`bytes_left`==1). `bytes_left` decrements on every handshake.
- `start` while `busy`=1 is ignored; captured parameters are not altered.
- `mem_address` holds its last value when `mem_chipselect`=0.
- Reset (any time, including mid-transfer): state=IDLE, FIFO and `inflight` cleared, idx=0. A read returning after reset is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_chipselect`=0, `mem_address`=0. `mem_write`=0, `mem_byteenable`=4'hF and `mem_clken`=1 at all times.
- Start latency (with `start` sampled at cycle 0):
  - Cycle 1: `busy`=1, `mem_chipselect`=1, `mem_address`=base.
  - Cycle 2: data pushed.
  - Cycle 3: first `out_valid`.
- Throughput: one byte per cycle sustained with `out_ready` held at 1. With `FIFO_DEPTH`≥2, no bubbles occur after the first byte.
- An N-word transfer with `out_ready`=1 shows its last handshake at cycle 4N+2 and `done` at cycle 4N+3.
- `out_valid`/`out_data`/`out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- Push and pop in the same cycle on a full FIFO are legal; the count is unchanged.

## Test plan
- Single word: base=0x0010, count=1, RAM[0x10]=0x44332211, `out_ready`=1 → exactly one read at cycle 1; bytes 0x11, 0x22, 0x33, 0x44 on cycles 3–6; `out_last` only on 0x44; `done` at cycle 7.
- Streaming: count=8, `out_ready`=1 → 32 contiguous bytes with no `out_valid` gaps; addresses base..base+7 issued once each; `done` at cycle 35.
- Backpressure: count=16, `out_ready` toggled at random with a 30% duty cycle → byte sequence matches RAM contents; never more than `FIFO_DEPTH` outstanding words (reads + FIFO); output stays stable while stalled.
- Wrap and zero: base=0x7FFE, count=3 → reads at 0x7FFE, 0x7FFF, 0x0000. count=0 → `done` one cycle after `start`, no `mem_chipselect`.
- Reset mid-transfer: assert `reset` during word 2 of 8 → all outputs return to their reset values immediately. A new `start` (base=0x100, count=1) then yields clean bytes from RAM[0x100] only.
- `start` while busy: pulse `start` with different parameters during RUN → ignored; the original transfer completes unchanged.
